// File: rtl/rv_pkg.sv
// Shared RISC-V definitions: major opcodes (instr[6:2]), hazard FSM states,
// and helpers describing which source registers an instruction reads.
package rv_pkg;

    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] OP     = 5'b01100;
    localparam logic [4:0] OP_IMM = 5'b00100;
    localparam logic [4:0] BRANCH = 5'b11000;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] AUIPC  = 5'b00101;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } hz_state_e;

    // rs1 is read by everything except the U-type ops and JAL.
    function automatic logic uses_rs1(input logic [4:0] opcode);
        return !(opcode == LUI || opcode == AUIPC || opcode == JAL);
    endfunction

    // rs2 is read only by register-register ALU ops, stores and branches.
    function automatic logic uses_rs2(input logic [4:0] opcode);
        return (opcode == OP || opcode == STORE || opcode == BRANCH);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts qualifying events, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and halt controller beside the D/E register: load-use stalls,
// taken-branch flushes, halt drain sequencing and performance counters.
//
// state  | meaning
// -------+------------------------------------------------------------
// RUN    | normal operation; halt > taken branch > load-use
// DRAIN  | halt left E, older instructions retiring; front end frozen
// HALTED | core stopped; sticky until reset
module hazard_ctrl
    import rv_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode_d,
    input  logic [4:0]       rs1_index_d,
    input  logic [4:0]       rs2_index_d,
    input  logic [4:0]       opcode_e,
    input  logic [4:0]       rd_index_e,
    input  logic             wb_en_e,
    input  logic             next_pc_sel_e,
    input  logic             halt_e,
    output logic             stall_pc,
    output logic             stall_f_d,
    output logic             flush_f_d,
    output logic             flush_d_e,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

    hz_state_e     state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          halted_q, halted_d;
    logic          load_use;
    logic          stall_inc;
    logic          flush_inc;

    // Load in E whose destination feeds a source D actually reads.
    always_comb begin
        load_use = (opcode_e == LOAD) && wb_en_e && (rd_index_e != 5'd0) &&
                   ((uses_rs1(opcode_d) && (rs1_index_d == rd_index_e)) ||
                    (uses_rs2(opcode_d) && (rs2_index_d == rd_index_e)));
    end

    // Next-state and combinational pipeline controls.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_pc    = 1'b0;
        stall_f_d   = 1'b0;
        flush_f_d   = 1'b0;
        flush_d_e   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            RUN: begin
                if (halt_e) begin
                    // Nothing younger than the halt may enter the pipe.
                    stall_pc    = 1'b1;
                    flush_f_d   = 1'b1;
                    flush_d_e   = 1'b1;
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end else if (next_pc_sel_e) begin
                    // D is wrong-path, so any load-use stall on it is moot.
                    flush_f_d = 1'b1;
                    flush_d_e = 1'b1;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    stall_pc  = 1'b1;
                    stall_f_d = 1'b1;
                    flush_d_e = 1'b1;
                    stall_inc = 1'b1;
                end
            end
            DRAIN: begin
                stall_pc    = 1'b1;
                stall_f_d   = 1'b1;
                flush_d_e   = 1'b1;
                drain_cnt_d = drain_cnt_q - DW'(1);
                // <= rather than == so a zero drain length cannot wedge here.
                if (drain_cnt_q <= DW'(1)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                stall_pc  = 1'b1;
                stall_f_d = 1'b1;
                flush_d_e = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        halted_d = (state_d == HALTED);
    end

    // State, drain timer and registered halted flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= halted_d;
        end
    end

    assign halted = halted_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl with 4-bit counters so saturation is reachable.
module tb_hazard_ctrl;

    localparam int CW  = 4;
    localparam int DC  = 2;
    localparam int MAX = (1 << CW) - 1;

    localparam logic [4:0] O_LOAD = 5'b00000, O_STORE = 5'b01000, O_OP = 5'b01100,
                           O_OPI = 5'b00100, O_BR = 5'b11000, O_JAL = 5'b11011,
                           O_JALR = 5'b11001, O_LUI = 5'b01101, O_AUIPC = 5'b00101;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    opcode_d, rs1_index_d, rs2_index_d, opcode_e, rd_index_e;
    logic          wb_en_e, next_pc_sel_e, halt_e;
    logic          stall_pc, stall_f_d, flush_f_d, flush_d_e, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode_d      (opcode_d),
        .rs1_index_d   (rs1_index_d),
        .rs2_index_d   (rs2_index_d),
        .opcode_e      (opcode_e),
        .rd_index_e    (rd_index_e),
        .wb_en_e       (wb_en_e),
        .next_pc_sel_e (next_pc_sel_e),
        .halt_e        (halt_e),
        .stall_pc      (stall_pc),
        .stall_f_d     (stall_f_d),
        .flush_f_d     (flush_f_d),
        .flush_d_e     (flush_d_e),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    int tests_run = 0;
    int failed    = 0;

    // Reference model: "stopping" plus the number of cycles elapsed since
    // the halt was accepted; counters as plain integers clamped at MAX.
    bit m_stopping = 1'b0;
    int m_age      = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    function automatic bit f_load_use();
        bit r1 = !(opcode_d inside {O_LUI, O_AUIPC, O_JAL});
        bit r2 = opcode_d inside {O_OP, O_STORE, O_BR};
        return (opcode_e == O_LOAD) && wb_en_e && (rd_index_e != 0) &&
               ((r1 && rs1_index_d == rd_index_e) || (r2 && rs2_index_d == rd_index_e));
    endfunction

    // {stall_pc, stall_f_d, flush_f_d, flush_d_e}
    function automatic logic [3:0] exp_ctrl();
        if (m_stopping)    return 4'b1101;
        if (halt_e)        return 4'b1011;
        if (next_pc_sel_e) return 4'b0011;
        if (f_load_use())  return 4'b1101;
        return 4'b0000;
    endfunction

    function automatic logic exp_halted();
        return m_stopping && (m_age > DC);
    endfunction

    function automatic logic [3:0] ctrl();
        return {stall_pc, stall_f_d, flush_f_d, flush_d_e};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_stopping = 1'b0; m_age = 0; m_stall = 0; m_flush = 0;
        end else if (!m_stopping) begin
            if (halt_e) begin
                m_stopping = 1'b1; m_age = 1;
            end else if (next_pc_sel_e) begin
                if (m_flush < MAX) m_flush++;
            end else if (f_load_use()) begin
                if (m_stall < MAX) m_stall++;
            end
        end else if (m_age < 1000) begin
            m_age++;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] od, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] oe, input logic [4:0] rd, input logic wb,
                         input logic br, input logic hl);
        opcode_d = od; rs1_index_d = r1; rs2_index_d = r2;
        opcode_e = oe; rd_index_e = rd; wb_en_e = wb;
        next_pc_sel_e = br; halt_e = hl;
        #1;
    endtask

    task automatic idle();
        drive(O_OPI, 0, 0, O_OPI, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (ctrl() !== 4'b0000) begin failed++; $display("FAIL reset_ctrl got %b exp 0000", ctrl()); end
        tests_run++;
        if (halted !== 1'b0) begin failed++; $display("FAIL reset_halted got %b exp 0", halted); end
        tests_run++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            failed++; $display("FAIL reset_counters got stall=%0d flush=%0d exp 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        int s0 = m_stall;
        drive(O_OP, 1, 5, O_LOAD, 5, 1, 0, 0);
        tests_run++;
        if (ctrl() !== 4'b1101) begin failed++; $display("FAIL load_use_ctrl got %b exp 1101", ctrl()); end
        tick();
        idle();
        tests_run++;
        if (ctrl() !== 4'b0000) begin failed++; $display("FAIL load_use_one_bubble got %b exp 0000", ctrl()); end
        tests_run++;
        if (int'(stall_cnt) !== s0 + 1) begin
            failed++; $display("FAIL load_use_stall_cnt got %0d exp %0d", stall_cnt, s0 + 1);
        end
    endtask

    task automatic test_no_false_hazard();
        int s0 = m_stall;
        drive(O_OP, 0, 0, O_LOAD, 0, 1, 0, 0);
        tests_run++;
        if (ctrl() !== 4'b0000) begin failed++; $display("FAIL nohaz_rd0 got %b exp 0000", ctrl()); end
        tick();
        drive(O_LUI, 7, 7, O_LOAD, 7, 1, 0, 0);
        tests_run++;
        if (ctrl() !== 4'b0000) begin failed++; $display("FAIL nohaz_lui got %b exp 0000", ctrl()); end
        tick();
        drive(O_OPI, 3, 9, O_LOAD, 9, 1, 0, 0);
        tests_run++;
        if (ctrl() !== 4'b0000) begin failed++; $display("FAIL nohaz_opimm_rs2 got %b exp 0000", ctrl()); end
        tick();
        drive(O_STORE, 2, 6, O_OPI, 6, 1, 0, 0);
        tests_run++;
        if (ctrl() !== 4'b0000) begin failed++; $display("FAIL nohaz_not_load got %b exp 0000", ctrl()); end
        tick();
        drive(O_BR, 4, 4, O_LOAD, 4, 0, 0, 0);
        tests_run++;
        if (ctrl() !== 4'b0000) begin failed++; $display("FAIL nohaz_no_wb got %b exp 0000", ctrl()); end
        tick();
        idle();
        tests_run++;
        if (int'(stall_cnt) !== s0) begin failed++; $display("FAIL nohaz_stall_cnt got %0d exp %0d", stall_cnt, s0); end
    endtask

    task automatic test_branch_over_load_use();
        int s0 = m_stall;
        int f0 = m_flush;
        drive(O_OP, 5, 5, O_LOAD, 5, 1, 1, 0);
        tests_run++;
        if (ctrl() !== 4'b0011) begin failed++; $display("FAIL branch_ctrl got %b exp 0011", ctrl()); end
        tick();
        idle();
        tests_run++;
        if (int'(flush_cnt) !== f0 + 1 || int'(stall_cnt) !== s0) begin
            failed++;
            $display("FAIL branch_counters got flush=%0d stall=%0d exp %0d/%0d", flush_cnt, stall_cnt, f0 + 1, s0);
        end
    endtask

    task automatic test_halt();
        drive(O_OP, 5, 5, O_LOAD, 5, 1, 0, 1);
        tests_run++;
        if (ctrl() !== 4'b1011) begin failed++; $display("FAIL halt_t_ctrl got %b exp 1011", ctrl()); end
        tick();
        drive(O_OP, 5, 5, O_LOAD, 5, 1, 1, 0);
        tests_run++;
        if (ctrl() !== 4'b1101 || halted !== 1'b0) begin
            failed++; $display("FAIL halt_t1 got ctrl=%b halted=%b exp 1101/0", ctrl(), halted);
        end
        tick();
        idle();
        tests_run++;
        if (ctrl() !== 4'b1101 || halted !== 1'b0) begin
            failed++; $display("FAIL halt_t2 got ctrl=%b halted=%b exp 1101/0", ctrl(), halted);
        end
        for (int i = 3; i < 7; i++) begin
            tick();
            drive(5'($urandom), 5'($urandom), 5'($urandom), O_LOAD, 5'($urandom_range(1, 3)),
                  1, 1'($urandom), 1'($urandom));
            tests_run++;
            if (ctrl() !== 4'b1101 || halted !== 1'b1) begin
                failed++; $display("FAIL halt_t%0d got ctrl=%b halted=%b exp 1101/1", i, ctrl(), halted);
            end
        end
    endtask

    task automatic test_reset_in_drain();
        drive(O_OPI, 0, 0, O_OPI, 0, 0, 0, 1);
        tick();
        rst = 1'b0;
        idle();
        tests_run++;
        if (ctrl() !== 4'b1101) begin failed++; $display("FAIL drain_rst_t1 got %b exp 1101", ctrl()); end
        tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (ctrl() !== 4'b0000 || halted !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
            failed++;
            $display("FAIL drain_rst_t2 got ctrl=%b halted=%b stall=%0d flush=%0d exp 0000/0/0/0",
                     ctrl(), halted, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_saturation();
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            drive(O_STORE, 5'(i % 3 + 1), 5'(i % 7 + 8), O_LOAD, 5'(i % 7 + 8), 1, 0, 0);
            if (ctrl() !== 4'b1101) bad++;
            tick();
        end
        idle();
        tests_run++;
        if (bad != 0) begin failed++; $display("FAIL sat_stall_cycles got %0d bad cycles exp 0", bad); end
        tests_run++;
        if (int'(stall_cnt) !== MAX) begin failed++; $display("FAIL sat_stall_cnt got %0d exp %0d", stall_cnt, MAX); end
    endtask

    task automatic test_random();
        logic [4:0] ops [9] = '{O_LOAD, O_STORE, O_OP, O_OPI, O_BR, O_JAL, O_JALR, O_LUI, O_AUIPC};
        int bad_ctrl = 0, bad_halt = 0, bad_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            drive(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? O_LOAD : ops[$urandom_range(0, 8)],
                  5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 49) == 0));
            if (ctrl() !== exp_ctrl()) begin
                bad_ctrl++;
                if (bad_ctrl < 4) $display("FAIL rand_ctrl cycle %0d got %b exp %b", i, ctrl(), exp_ctrl());
            end
            if (halted !== exp_halted()) bad_halt++;
            if (int'(stall_cnt) !== m_stall || int'(flush_cnt) !== m_flush) bad_cnt++;
            tick();
        end
        rst = 1'b1;
        tests_run++;
        if (bad_ctrl != 0) begin failed++; $display("FAIL rand_ctrl_total got %0d bad cycles exp 0", bad_ctrl); end
        tests_run++;
        if (bad_halt != 0) begin failed++; $display("FAIL rand_halted got %0d bad cycles exp 0", bad_halt); end
        tests_run++;
        if (bad_cnt != 0) begin failed++; $display("FAIL rand_counters got %0d bad cycles exp 0", bad_cnt); end
    endtask

    initial begin
        rst = 1'b0;
        opcode_d = '0; rs1_index_d = '0; rs2_index_d = '0;
        opcode_e = '0; rd_index_e = '0; wb_en_e = 1'b0;
        next_pc_sel_e = 1'b0; halt_e = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_branch_over_load_use();
        test_halt();
        test_reset();
        test_reset_in_drain();
        test_saturation();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
